// File: rtl/mdio_pkg.sv
// Shared MDIO management-frame definitions (states, frame layout, field widths).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mdio_pkg;

  // Field widths of a clause-22 management frame
  localparam int ST_W    = 2;
  localparam int OP_W    = 2;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int TA_W    = 2;

  localparam int FRAME_BITS = 32;
  localparam int DATA_BITS  = 16;
  localparam int DATA_W     = DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  // Header bits following ST: OP, PHYAD, REGAD
  localparam int HDR_BITS = OP_W + PHYAD_W + REGAD_W;

  localparam logic [ST_W-1:0] ST    = 2'b01;
  localparam logic [OP_W-1:0] OP_WR = 2'b01;
  localparam logic [OP_W-1:0] OP_RD = 2'b10;

  // Bit-counter values of the last bit of each frame section
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(ST_W + HDR_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_TA_LAST  = CNT_W'(ST_W + HDR_BITS + TA_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST1,
    S_HDR,
    S_WTA,
    S_WDATA,
    S_WDONE,
    S_RTA,
    S_RDATA,
    S_RDONE,
    S_SKIP
  } mdio_state_e;

endpackage

// File: rtl/mdc_edge_det.sv
// Registers mdc in the clk domain and flags its rising and falling edges.
// Latency: rise/fall are high the first clk cycle mdc is seen at its new level.
// Backpressure: none; pure edge detector.
module mdc_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  output logic rise,
  output logic fall
);

  logic mdc_q;

  // Previous-cycle copy of mdc for edge comparison
  always_ff @(posedge clk) begin
    if (reset) mdc_q <= 1'b0;
    else       mdc_q <= mdc;
  end

  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_receiver.sv
// MDIO frame receiver: decodes write/read frames, strobes the register file, returns read data.
// Latency: WR_STB/MDIO_DONE 1 clk after the last data-bit rise; RD_STB 1 clk after REGAD bit 0.
// Backpressure: none; the transmitter paces everything through mdc, aborts on MDIO_OE low.
module mdio_receiver
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'd31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mdc,
  input  logic               MDIO_OUT,
  input  logic               MDIO_OE,
  input  logic [DATA_W-1:0]  RD_DATA,
  output logic               MDIO_IN,
  output logic [REGAD_W-1:0] ADDR,
  output logic [DATA_W-1:0]  WR_DATA,
  output logic               WR_STB,
  output logic               RD_STB,
  output logic               MDIO_DONE
);

  logic rise;
  logic fall;

  mdc_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .mdc   (mdc),
    .rise  (rise),
    .fall  (fall)
  );

  mdio_state_e        state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shreg;
  logic               rd_load;

  // Full header as it stands once REGAD bit 0 arrives on the current rise
  logic [HDR_BITS-1:0] hdr;
  logic [OP_W-1:0]     hdr_op;
  logic [PHYAD_W-1:0]  hdr_phy;
  logic [REGAD_W-1:0]  hdr_regad;

  assign hdr       = {shreg[HDR_BITS-2:0], MDIO_OUT};
  assign hdr_op    = hdr[HDR_BITS-1 -: OP_W];
  assign hdr_phy   = hdr[PHYAD_W+REGAD_W-1 -: PHYAD_W];
  assign hdr_regad = hdr[REGAD_W-1:0];

  // Frame FSM with registered strobes, address, write data and serial read output
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      rd_load   <= 1'b0;
      MDIO_IN   <= 1'b0;
      ADDR      <= '0;
      WR_DATA   <= '0;
      WR_STB    <= 1'b0;
      RD_STB    <= 1'b0;
      MDIO_DONE <= 1'b0;
    end else begin
      WR_STB    <= 1'b0;
      RD_STB    <= 1'b0;
      MDIO_DONE <= 1'b0;
      rd_load   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rise && MDIO_OE && (MDIO_OUT == ST[1])) begin
            state <= S_ST1;
            cnt   <= CNT_W'(1);
          end
        end

        S_ST1: begin
          if (rise) begin
            if (MDIO_OE && (MDIO_OUT == ST[0])) begin
              state <= S_HDR;
              cnt   <= cnt + 1'b1;
            end else begin
              state <= S_IDLE;
              cnt   <= '0;
            end
          end
        end

        S_HDR: begin
          if (rise) begin
            if (!MDIO_OE) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              shreg <= {shreg[DATA_W-2:0], MDIO_OUT};
              cnt   <= cnt + 1'b1;
              if (cnt == CNT_HDR_LAST) begin
                // Foreign PHY or unsupported opcode: ride out the frame silently
                if (hdr_phy != PHY_ADDR) begin
                  state <= S_SKIP;
                end else if (hdr_op == OP_WR) begin
                  state <= S_WTA;
                  ADDR  <= hdr_regad;
                end else if (hdr_op == OP_RD) begin
                  state  <= S_RTA;
                  ADDR   <= hdr_regad;
                  RD_STB <= 1'b1;
                end else begin
                  state <= S_SKIP;
                end
              end
            end
          end
        end

        S_WTA: begin
          if (rise) begin
            if (!MDIO_OE) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_TA_LAST) state <= S_WDATA;
            end
          end
        end

        S_WDATA: begin
          if (rise) begin
            if (!MDIO_OE) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              shreg <= {shreg[DATA_W-2:0], MDIO_OUT};
              cnt   <= cnt + 1'b1;
              if (cnt == CNT_LAST) begin
                state     <= S_WDONE;
                WR_DATA   <= {shreg[DATA_W-2:0], MDIO_OUT};
                WR_STB    <= 1'b1;
                MDIO_DONE <= 1'b1;
              end
            end
          end
        end

        S_WDONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end

        S_RTA: begin
          // Register file answers the cycle after RD_STB; grab it one cycle later
          rd_load <= RD_STB;
          if (rd_load) shreg <= RD_DATA;
          if (rise) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_TA_LAST) state <= S_RDATA;
          end
        end

        S_RDATA: begin
          // Drive on mdc falls so the bit is settled at the transmitter's rising sample
          if (fall) begin
            MDIO_IN <= shreg[DATA_W-1];
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
          end
          if (rise) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= S_RDONE;
              MDIO_DONE <= 1'b1;
              MDIO_IN   <= 1'b0;
            end
          end
        end

        S_RDONE: begin
          MDIO_IN <= 1'b0;
          state   <= S_IDLE;
          cnt     <= '0;
        end

        S_SKIP: begin
          if (rise) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_receiver.sv
// Scoreboard bench for mdio_receiver: two instances (PHY_ADDR 31 and 5) share one MDIO bus.
// Stimulus pushes expected strobe events / static snapshots; a negedge monitor pops and compares.
// No backpressure on the bus; every wait is a fixed clk count.
module tb_mdio_receiver;
  import mdio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data;

  logic        a_in, a_wr, a_rd, a_done;
  logic [4:0]  a_addr;
  logic [15:0] a_wdata;
  logic        b_in, b_wr, b_rd, b_done;
  logic [4:0]  b_addr;
  logic [15:0] b_wdata;

  always #5 clk = ~clk;

  mdio_receiver #(.PHY_ADDR(5'd31)) u_dut_a (
    .clk(clk), .reset(reset), .mdc(mdc), .MDIO_OUT(mdio_out), .MDIO_OE(mdio_oe),
    .RD_DATA(rd_data), .MDIO_IN(a_in), .ADDR(a_addr), .WR_DATA(a_wdata),
    .WR_STB(a_wr), .RD_STB(a_rd), .MDIO_DONE(a_done)
  );

  mdio_receiver #(.PHY_ADDR(5'd5)) u_dut_b (
    .clk(clk), .reset(reset), .mdc(mdc), .MDIO_OUT(mdio_out), .MDIO_OE(mdio_oe),
    .RD_DATA(rd_data), .MDIO_IN(b_in), .ADDR(b_addr), .WR_DATA(b_wdata),
    .WR_STB(b_wr), .RD_STB(b_rd), .MDIO_DONE(b_done)
  );

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic        done;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } ev_t;

  typedef struct packed {
    logic        d;
    logic [4:0]  addr;
    logic [15:0] wdata;
  } snap_t;

  ev_t   qa[$];
  ev_t   qb[$];
  snap_t sq[$];

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] rd_cap = '0;
  logic        rd_win = 1'b0;
  logic        fin = 1'b0;
  logic        fin_done = 1'b0;

  function automatic ev_t mk(input logic w, input logic r, input logic dn,
                             input logic [4:0] ad, input logic [15:0] wd, input logic [15:0] rdd);
    ev_t e;
    e.wr = w; e.rd = r; e.done = dn; e.addr = ad; e.wdata = wd; e.rdata = rdd;
    return e;
  endfunction

  function automatic snap_t mks(input logic d, input logic [4:0] ad, input logic [15:0] wd);
    snap_t s;
    s.d = d; s.addr = ad; s.wdata = wd;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ev(input string tag, input ev_t e, input logic w, input logic r,
                          input logic dn, input logic [4:0] ad, input logic [15:0] wd);
    chk({tag, "_strobes"}, {29'd0, w, r, dn}, {29'd0, e.wr, e.rd, e.done});
    chk({tag, "_addr"}, {27'd0, ad}, {27'd0, e.addr});
    if (e.wr) chk({tag, "_wr_data"}, {16'd0, wd}, {16'd0, e.wdata});
    if (e.done && !e.wr) chk({tag, "_rd_serial"}, {16'd0, rd_cap}, {16'd0, e.rdata});
  endtask

  task automatic check_snap(input string tag, input snap_t s, input logic [4:0] ad,
                            input logic [15:0] wd, input logic mi, input logic w,
                            input logic r, input logic dn);
    chk({tag, "_addr"}, {27'd0, ad}, {27'd0, s.addr});
    chk({tag, "_wr_data"}, {16'd0, wd}, {16'd0, s.wdata});
    chk({tag, "_mdio_in"}, {31'd0, mi}, 32'd0);
    chk({tag, "_strobes"}, {29'd0, w, r, dn}, 32'd0);
  endtask

  // Monitor: pops expected events on strobes, processes snapshots, checks idle MDIO_IN
  always @(negedge clk) begin
    if (a_wr || a_rd || a_done) begin
      if (qa.size() == 0) chk("dut31_unexpected_strobe", {29'd0, a_wr, a_rd, a_done}, 32'd0);
      else check_ev("dut31", qa.pop_front(), a_wr, a_rd, a_done, a_addr, a_wdata);
    end
    if (b_wr || b_rd || b_done) begin
      if (qb.size() == 0) chk("dut5_unexpected_strobe", {29'd0, b_wr, b_rd, b_done}, 32'd0);
      else check_ev("dut5", qb.pop_front(), b_wr, b_rd, b_done, b_addr, b_wdata);
    end
    while (sq.size() > 0) begin
      snap_t s;
      s = sq.pop_front();
      if (s.d == 1'b0) check_snap("snap_dut31", s, a_addr, a_wdata, a_in, a_wr, a_rd, a_done);
      else             check_snap("snap_dut5",  s, b_addr, b_wdata, b_in, b_wr, b_rd, b_done);
    end
    if (mdc && !rd_win) chk("dut31_mdio_in_idle", {31'd0, a_in}, 32'd0);
    if (mdc)            chk("dut5_mdio_in_idle",  {31'd0, b_in}, 32'd0);
    if (fin && !fin_done) begin
      chk("dut31_events_left", qa.size(), 32'd0);
      chk("dut5_events_left",  qb.size(), 32'd0);
      fin_done = 1'b1;
    end
  end

  task automatic half_period();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int k = 0; k < n; k++) begin
      mdio_oe = 1'b0; mdio_out = 1'b1;
      half_period(); mdc = 1'b1;
      half_period(); mdc = 1'b0;
    end
  endtask

  // Transmitter model: one bit per mdc period, data set while mdc is low
  task automatic send_frame(input logic [31:0] f, input bit is_rd,
                            input int abort_at, input int reset_at);
    bit dropped;
    dropped = 1'b0;
    rd_cap  = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i == abort_at) dropped = 1'b1;
      if (is_rd && i == 15) rd_win = 1'b1;
      mdio_oe  = !(dropped || (is_rd && i <= 17));
      mdio_out = f[i];
      half_period();
      if (is_rd && i <= 15) rd_cap = {rd_cap[14:0], a_in};
      mdc = 1'b1;
      if (i == reset_at) begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sq.push_back(mks(1'b0, 5'h00, 16'h0000));
        sq.push_back(mks(1'b1, 5'h00, 16'h0000));
        dropped = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        half_period();
      end
      mdc = 1'b0;
    end
    mdio_oe = 1'b0; mdio_out = 1'b1; rd_win = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mdc = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b1; rd_data = 16'h0EC6;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sq.push_back(mks(1'b0, 5'h00, 16'h0000));
    sq.push_back(mks(1'b1, 5'h00, 16'h0000));
    idle_bits(2);

    // Invalid start (ST=00): nothing may happen on either instance
    send_frame(32'h2FE5946D, 1'b0, -1, -1);
    idle_bits(6);
    sq.push_back(mks(1'b0, 5'h00, 16'h0000));
    sq.push_back(mks(1'b1, 5'h00, 16'h0000));

    // Write REGAD 0x12 <- 0x28DB to PHY 31
    qa.push_back(mk(1'b1, 1'b0, 1'b1, 5'h12, 16'h28DB, 16'h0000));
    send_frame(32'h5FCB28DB, 1'b0, -1, -1);
    idle_bits(6);

    // Read REGAD 0x12 from PHY 31, register file returns 0x0EC6
    qa.push_back(mk(1'b0, 1'b1, 1'b0, 5'h12, 16'h0000, 16'h0000));
    qa.push_back(mk(1'b0, 1'b0, 1'b1, 5'h12, 16'h0000, 16'h0EC6));
    send_frame(32'h6FCB28DB, 1'b1, -1, -1);
    idle_bits(6);

    // Write to PHY 5 (REGAD 3 <- 0xA5C3): only the PHY_ADDR=5 instance answers
    qb.push_back(mk(1'b1, 1'b0, 1'b1, 5'h03, 16'hA5C3, 16'h0000));
    send_frame(32'h528EA5C3, 1'b0, -1, -1);
    idle_bits(6);
    sq.push_back(mks(1'b0, 5'h12, 16'h28DB));
    sq.push_back(mks(1'b1, 5'h03, 16'hA5C3));

    // Write REGAD 7 <- 0x1234 aborted at data bit 8: ADDR moved, WR_DATA held
    send_frame(32'h5F9E1234, 1'b0, 8, -1);
    idle_bits(6);
    sq.push_back(mks(1'b0, 5'h07, 16'h28DB));
    sq.push_back(mks(1'b1, 5'h03, 16'hA5C3));

    // Read REGAD 9, reset while a 1 bit (data bit 11) is on MDIO_IN
    qa.push_back(mk(1'b0, 1'b1, 1'b0, 5'h09, 16'h0000, 16'h0000));
    send_frame(32'h6FA40000, 1'b1, -1, 11);
    idle_bits(6);

    // Back-to-back: write REGAD 5 <- 0xBEEF, then read REGAD 0x1C returning 0x9A3C
    qa.push_back(mk(1'b1, 1'b0, 1'b1, 5'h05, 16'hBEEF, 16'h0000));
    send_frame(32'h5F96BEEF, 1'b0, -1, -1);
    rd_data = 16'h9A3C;
    qa.push_back(mk(1'b0, 1'b1, 1'b0, 5'h1C, 16'h0000, 16'h0000));
    qa.push_back(mk(1'b0, 1'b0, 1'b1, 5'h1C, 16'h0000, 16'h9A3C));
    send_frame(32'h6FF00000, 1'b1, -1, -1);
    idle_bits(6);
    sq.push_back(mks(1'b0, 5'h1C, 16'hBEEF));
    sq.push_back(mks(1'b1, 5'h00, 16'h0000));

    fin = 1'b1;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
